// File: rtl/result_accumulator.sv
// result_accumulator: sums groups of NUM_ACC adder results and emits one sum per group over valid/ready.
// Optional saturation: define RESULT_ACC_SAT_EN to clamp on overflow and report a sticky per-group out_sat.
module result_accumulator #(
    parameter int DATA_IN_WIDTH = 8,
    parameter int NUM_ACC       = 4,
    parameter int ACC_WIDTH     = 11,
    parameter int CNT_WIDTH     = $clog2(NUM_ACC + 1)
) (
    input  logic                     clk_i,
    input  logic                     arst_n,
    input  logic [DATA_IN_WIDTH:0]   in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush_i,
    output logic [ACC_WIDTH-1:0]     out_sum,
    output logic [CNT_WIDTH-1:0]     out_cnt,
    output logic                     out_sat,
    output logic                     out_valid,
    input  logic                     out_ready
);
    typedef enum logic {ACCUM, HOLD} state_e;
    state_e state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d, sum_q, sum_d, base_acc, add_res, acc_nx;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, ocnt_q, ocnt_d, base_cnt, new_cnt;
    logic beat, close;

    // In HOLD the input is only open when the pending sum is leaving this cycle.
    assign in_ready  = (state_q == HOLD) ? out_ready : 1'b1;
    assign out_valid = (state_q == HOLD);
    assign beat      = in_valid && in_ready;
    assign out_sum   = sum_q;
    assign out_cnt   = ocnt_q;

    // A beat accepted in HOLD starts a fresh group, so the running totals restart from zero.
    always_comb begin
        base_acc = (state_q == HOLD) ? '0 : acc_q;
        base_cnt = (state_q == HOLD) ? '0 : cnt_q;
        new_cnt  = base_cnt + CNT_WIDTH'(beat);
        acc_nx   = beat ? add_res : base_acc;
        close    = (beat && new_cnt == CNT_WIDTH'(NUM_ACC)) ||
                   (state_q == ACCUM && flush_i && new_cnt != '0);
    end

`ifdef RESULT_ACC_SAT_EN
    localparam int AW1 = ACC_WIDTH + 1;
    logic [ACC_WIDTH:0] wide;
    logic sat_q, sat_d, osat_q, osat_d, base_sat, sat_nx;

    // Clamp to all-ones when the true sum leaves the accumulator range; the sat flag sticks for the group.
    always_comb begin
        wide     = {1'b0, base_acc} + AW1'(in_data);
        add_res  = wide[ACC_WIDTH] ? '1 : wide[ACC_WIDTH-1:0];
        base_sat = (state_q == HOLD) ? 1'b0 : sat_q;
        sat_nx   = base_sat | (beat & wide[ACC_WIDTH]);
        sat_d    = close ? 1'b0 : sat_nx;
        osat_d   = close ? sat_nx : osat_q;
    end

    // Saturation flag registers.
    always_ff @(posedge clk_i) begin
        if (!arst_n) begin
            sat_q  <= 1'b0;
            osat_q <= 1'b0;
        end else begin
            sat_q  <= sat_d;
            osat_q <= osat_d;
        end
    end

    assign out_sat = osat_q;
`else
    assign add_res = base_acc + ACC_WIDTH'(in_data);
    assign out_sat = 1'b0;
`endif

    // Next state: closing a group loads the output registers and clears the running totals.
    always_comb begin
        state_d = state_q;
        acc_d   = close ? '0 : acc_nx;
        cnt_d   = close ? '0 : new_cnt;
        sum_d   = close ? acc_nx : sum_q;
        ocnt_d  = close ? new_cnt : ocnt_q;
        if (close)
            state_d = HOLD;
        else if (state_q == HOLD && out_ready)
            state_d = ACCUM;
    end

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (!arst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            ocnt_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            ocnt_q  <= ocnt_d;
        end
    end
endmodule

// File: doc/result_accumulator.md
Name: result_accumulator

Overview:
- Downstream stage of the adder/FIFO datapath. Consumes the (DATA_IN_WIDTH+1)-bit adder results through a valid/ready interface.
- Sums groups of NUM_ACC consecutive results into a wider accumulator and emits one sum per group on a valid/ready output.
- A flush input emits a partial group early, which is used to drain the pipeline at end of stream.

Parameters:
- DATA_IN_WIDTH, 8: operand width of the upstream adder. Input result width is DATA_IN_WIDTH+1.
- NUM_ACC, 4: number of results per group. Must be ≥1.
- ACC_WIDTH, 11: accumulator/output width. Default equals DATA_IN_WIDTH+1+$clog2(NUM_ACC), so the default cannot overflow.
- CNT_WIDTH, $clog2(NUM_ACC+1): width of the beat-count output (derived; do not override).

Ports:
- clk_i  in  1  clock.
- arst_n  in  1  reset. Synchronous, active-low. One clock; reset is synchronous and active-low.
- in_data  in  DATA_IN_WIDTH+1  adder result, unsigned.
- in_valid  in  1  in_data valid.
- in_ready  out  1  accumulator can accept a beat.
- flush_i  in  1  close the current partial group.
- out_sum  out  ACC_WIDTH  group sum, unsigned.
- out_cnt  out  CNT_WIDTH  number of beats in out_sum (NUM_ACC, or fewer after a flush).
- out_sat  out  1  group saturated. Tied 0 unless RESULT_ACC_SAT_EN is defined.
- out_valid  out  1  out_sum/out_cnt/out_sat valid.
- out_ready  in  1  downstream accepts the output.

Behaviour:
- Reset (arst_n low at a rising edge):
  - state=ACCUM, acc=0, count=0.
  - out_valid=0, out_sum=0, out_cnt=0, out_sat=0, in_ready=1.
  - Applies mid-group or mid-HOLD. The partial or pending sum is discarded.
- Beat and transfer definitions:
  - A beat is accepted when in_valid && in_ready at a rising edge.
  - An output transfers when out_valid && out_ready.
- State ACCUM:
  - out_valid=0, in_ready=1.
  - On an accepted beat: acc += in_data (zero-extended to ACC_WIDTH), count++.
  - When the accepted beat makes count==NUM_ACC:
    - Next cycle: out_sum=final sum, out_cnt=NUM_ACC, out_valid=1, state=HOLD.
    - acc and count clear to 0.
  - Latency: out_valid rises exactly one cycle after the last beat of the group is accepted.
- Flush in ACCUM:
  - flush_i=1 with (count>0 or a beat accepted the same cycle) closes the group.
  - The same-cycle beat is included in the sum.
  - Next cycle: out_sum=partial sum, out_cnt=beats in the group, out_valid=1, state=HOLD.
  - Flush with count==0 and no beat is ignored.
- State HOLD:
  - out_valid=1. out_sum, out_cnt and out_sat are held stable until transfer.
  - in_ready = out_ready (combinational pass-through).
  - flush_i is ignored.
- Transfer in HOLD:
  - Transfer without an accepted beat: state=ACCUM, out_valid=0 next cycle.
  - Transfer with an accepted beat: that beat starts the new group (acc=in_data, count=1), state=ACCUM.
  - If NUM_ACC==1, that beat completes a group immediately: stay in HOLD with the new sum. This gives zero-bubble streaming.
- Backpressure:
  - out_ready=0 in HOLD stalls input (in_ready=0).
  - No beat is ever dropped or double-counted.
- Overflow (macro undefined): acc wraps modulo 2^ACC_WIDTH.
- Throughput: one output per NUM_ACC accepted beats, with no idle cycles when out_ready=1.

Optional Feature:
- Macro: RESULT_ACC_SAT_EN.
- Defined:
  - Any addition whose true result exceeds 2^ACC_WIDTH-1 clamps acc to all-ones.
  - A sticky per-group sat bit is set. It is presented on out_sat with the group and cleared when the next group starts.
- Undefined:
  - Wrap-around arithmetic.
  - out_sat tied 0, with no saturation logic.

Test Plan (DATA_IN_WIDTH=8, NUM_ACC=4, ACC_WIDTH=11 unless stated):
- Reset: hold arst_n=0 for 2 cycles with in_valid=1 → out_valid=0, out_sum=0, in_ready=1. No beat counted after release.
- Basic group: beats 10,20,30,40 back-to-back, out_ready=1 → out_valid one cycle after beat 40, out_sum=100, out_cnt=4. Second group 1,2,3,4 → 10, with no bubble.
- Backpressure: beats 511×4 with out_ready=0 for 5 cycles → in_ready=0 and out_sum=2044 held stable. Raise out_ready with in_valid=1 and data 7 → transfer and beat 7 accepted the same cycle. Next group 7,1,1,1 → 10.
- Flush:
  - Beats 3,5 then flush_i → out_sum=8, out_cnt=2.
  - flush_i with count 0 → no output.
  - Beat 1, then beat 7 with flush_i in the same cycle → out_sum=8, out_cnt=2.
- Overflow (ACC_WIDTH=10), beats 511,511,511,511:
  - Macro undefined → out_sum=1020, out_sat=0.
  - RESULT_ACC_SAT_EN defined → out_sum=1023, out_sat=1. Next group 1,1,1,1 → 4 with out_sat=0.
- Reset mid-group: beats 100,100, then reset, then 1,1,1,1 → out_sum=4, out_cnt=4.
